// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: operation select
// encoding and its width. Imported by the RTL and the testbench.
package usr_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

endpackage

// File: rtl/usr_next_mux.sv
// Next-state selector for univ_shift_reg. Purely combinational: picks the
// value the register takes on the next enabled edge for each of the eight
// modes. A 1-bit register has no neighbours, so rotates and ASR hold there.
module usr_next_mux
    import usr_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  d,
    input  logic [MODE_W-1:0] mode,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  next_q
);

    generate
        if (WIDTH == 1) begin : g_w1
            // Single-bit register: only the serial shifts move data
            always_comb begin
                next_q = q;
                case (mode)
                    MODE_HOLD: next_q = q;
                    MODE_LOAD: next_q = d;
                    MODE_SHL:  next_q = sin_r;
                    MODE_SHR:  next_q = sin_l;
                    MODE_ROL:  next_q = q;
                    MODE_ROR:  next_q = q;
                    MODE_ASR:  next_q = q;
                    MODE_CLR:  next_q = RESET_VAL;
                    default:   next_q = q;
                endcase
            end
        end else begin : g_wn
            // Multi-bit register: full shift/rotate decode
            always_comb begin
                next_q = q;
                case (mode)
                    MODE_HOLD: next_q = q;
                    MODE_LOAD: next_q = d;
                    MODE_SHL:  next_q = {q[WIDTH-2:0], sin_r};
                    MODE_SHR:  next_q = {sin_l, q[WIDTH-1:1]};
                    MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
                    MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
                    MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
                    MODE_CLR:  next_q = RESET_VAL;
                    default:   next_q = q;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, logical shifts, rotates, arithmetic
// shift right and clear, one cycle per operation, gated by en.
// Optional feature: define USR_PARITY_EN to add a registered even-parity
// output that always equals ^q.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_r,
    input  logic              sin_l,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r
`ifdef USR_PARITY_EN
    ,
    output logic              parity
`endif
);

    logic [WIDTH-1:0] next_q;

    usr_next_mux #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_next_mux (
        .q      (q),
        .d      (d),
        .mode   (mode),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .next_q (next_q)
    );

    // Register contents: async reset overrides everything, en gates updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= next_q;
        end
    end

`ifdef USR_PARITY_EN
    // Parity flop tracks q's next value so it never lags q by a cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= ^RESET_VAL;
        end else if (en) begin
            parity <= ^next_q;
        end
    end
`endif

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits, legal range 1..64.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded by reset and by CLR mode.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  update enable; when low, register holds regardless of mode.
REQ-006 Port mode  input  3  operation select, encoding per REQ-013.
REQ-007 Port d  input  WIDTH  parallel load data.
REQ-008 Port sin_r  input  1  serial input entering bit 0 on shift left.
REQ-009 Port sin_l  input  1  serial input entering bit WIDTH-1 on shift right.
REQ-010 Port q  output  WIDTH  register contents.
REQ-011 Port sout_l / sout_r  output  1 each  combinational copies of q[WIDTH-1] / q[0].
REQ-012 Port parity  output  1  registered even parity of q, present only under REQ-024.

Function
REQ-013 Mode encoding SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR.
REQ-014 On a rising clk edge with en=1: HOLD q<=q; LOAD q<=d; SHL q<={q[W-2:0],sin_r}; SHR q<={sin_l,q[W-1:1]}; ROL q<={q[W-2:0],q[W-1]}; ROR q<={q[0],q[W-1:1]}; ASR q<={q[W-1],q[W-1:1]}; CLR q<=RESET_VAL.
REQ-015 Latency SHALL be one cycle: q reflects the operation immediately after the sampling edge; no multi-cycle operations.
REQ-016 en=0 SHALL hold q on every edge, including with mode=CLR.
REQ-017 sout_l and sout_r SHALL be purely combinational from q, with no extra register stage.
REQ-018 WIDTH=1: SHL q<=sin_r, SHR q<=sin_l, ROL/ROR/ASR hold q.
REQ-019 Serial inputs SHALL be ignored in every mode other than SHL/SHR.
REQ-020 No undefined modes exist; all 8 encodings SHALL be decoded.

Reset
REQ-021 reset=1 SHALL force q to RESET_VAL immediately, without waiting for a clk edge, and SHALL hold it while asserted.
REQ-022 Assertion mid-operation SHALL override en and mode; the first update after deassertion SHALL occur on the first rising edge with reset=0.
REQ-023 Reset values: q=RESET_VAL, sout_l=RESET_VAL[W-1], sout_r=RESET_VAL[0], parity=^RESET_VAL.

Configuration
REQ-024 Macro USR_PARITY_EN SHALL control the parity output: when defined, it is a flop updated on the same edge as q to the XOR-reduction of q's next value, so parity always equals ^q.
REQ-025 When USR_PARITY_EN is undefined, the parity port and flop SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-026 Package usr_pkg SHALL hold the 3-bit mode constants (MODE_HOLD..MODE_CLR) and the mode width constant; RTL and bench SHALL both import it.
REQ-027 The next-state selector SHALL be one combinational sub-module, usr_next_mux (inputs q, d, mode, sin_l, sin_r; output next_q); the top module holds the flops only.

Verification
REQ-028 WIDTH=8, RESET_VAL=8'h00: pulse reset between clk edges at t=3 -> q=8'h00 before the next edge; parity=0.
REQ-029 LOAD d=8'hB4, then SHL sin_r=1 -> q=8'h69, then SHR sin_l=0 -> q=8'h34, with sout_l/sout_r tracking q[7]/q[0] the same cycle.
REQ-030 LOAD 8'h81, ROL -> 8'h03, ROR twice -> 8'h81 then 8'hC0; ASR on 8'h80 -> 8'hC0; ASR on 8'h40 -> 8'h20.
REQ-031 q=8'h5A, en=0, mode cycled through all 8 values over 8 edges -> q stays 8'h5A; then en=1, CLR with RESET_VAL=8'hF0 -> q=8'hF0.
REQ-032 Continuous SHL with reset asserted mid-cycle -> q=RESET_VAL asynchronously; after release, the first edge shifts from RESET_VAL.
REQ-033 USR_PARITY_EN defined, LOAD 8'h07 -> parity=1 the same cycle; SHL sin_r=0 -> q=8'h0E, parity=1; LOAD 8'h03 -> parity=0.
